// File: rtl/vreg_wb_packer.sv
// Vector writeback packer: gathers vl elements into one VLEN word
// and issues a single full-register write to the vector RF.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   cmd_*           command handshake (vrd, vl)
//   elem_*          element handshake (one DATA_WIDTH element)
//   vregw_en_o      RF write enable (one cycle)
//   vrd_addr_o      RF write address (registered)
//   vrd_data_o      RF write data (registered, elem0 in LSBs)
//   busy_o, done_o  status; done_o pulses once per command
module vreg_wb_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8,
  parameter int VLEN       = DATA_WIDTH * ELEMENTS,
  parameter int VLW        = $clog2(ELEMENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [4:0]            cmd_vrd_i,
  input  logic [VLW-1:0]        cmd_vl_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  input  logic [DATA_WIDTH-1:0] elem_data_i,
  output logic                  vregw_en_o,
  output logic [4:0]            vrd_addr_o,
  output logic [VLEN-1:0]       vrd_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam logic [VLW-1:0] MAX_VL = VLW'(ELEMENTS);

  state_t            state;
  state_t            state_d;
  logic [4:0]        vrd_q;
  logic [VLW-1:0]    vl_q;
  logic [VLW-1:0]    idx;
  logic [VLEN-1:0]   buf_q;

  logic              cmd_fire;
  logic              elem_fire;
  logic              last;
  logic [VLW-1:0]    vl_clamp;

  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign elem_fire = elem_valid_i && elem_ready_o;

  // Oversized requests still only fill one register.
  assign vl_clamp = (cmd_vl_i > MAX_VL) ? MAX_VL
                                        : cmd_vl_i;

  assign last = (idx + VLW'(1)) == vl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_d = (vl_clamp == '0) ? WRITE
                                     : COLLECT;
        end
      end
      COLLECT: begin
        if (elem_fire && last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready_o  = (state == IDLE);
  assign elem_ready_o = (state == COLLECT);
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == WRITE);

  // v0 and empty vectors complete without touching the RF.
  assign vregw_en_o = (state == WRITE)
                   && (vrd_q != '0)
                   && (vl_q != '0);

  assign vrd_addr_o = vrd_q;
  assign vrd_data_o = buf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vrd_q <= '0;
      vl_q  <= '0;
      idx   <= '0;
      buf_q <= '0;
    end else if (cmd_fire) begin
      vrd_q <= cmd_vrd_i;
      vl_q  <= vl_clamp;
      idx   <= '0;
      // Cleared up front so tail elements write as zero.
      buf_q <= '0;
    end else if (elem_fire) begin
      idx <= idx + VLW'(1);
      for (int k = 0; k < ELEMENTS; k++) begin
        if (idx == VLW'(k)) begin
          buf_q[k*DATA_WIDTH +: DATA_WIDTH] <= elem_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_vreg_wb_packer.sv
// Self-checking bench for vreg_wb_packer: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_vreg_wb_packer;

  localparam int DW   = 32;
  localparam int EL   = 8;
  localparam int VLEN = DW * EL;
  localparam int VLW  = $clog2(EL + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [4:0]      cmd_vrd_i = '0;
  logic [VLW-1:0]  cmd_vl_i = '0;
  logic            elem_valid_i = 1'b0;
  logic            elem_ready_o;
  logic [DW-1:0]   elem_data_i = '0;
  logic            vregw_en_o;
  logic [4:0]      vrd_addr_o;
  logic [VLEN-1:0] vrd_data_o;
  logic            busy_o;
  logic            done_o;

  vreg_wb_packer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_vrd_i    (cmd_vrd_i),
    .cmd_vl_i     (cmd_vl_i),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (elem_ready_o),
    .elem_data_i  (elem_data_i),
    .vregw_en_o   (vregw_en_o),
    .vrd_addr_o   (vrd_addr_o),
    .vrd_data_o   (vrd_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name,
                     logic [VLEN-1:0] act,
                     logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a phase, the accepted command, and
  // the list of elements received so far.
  int            m_phase = 0;  // 0 idle, 1 gathering, 2 writing
  logic [4:0]    m_vrd = '0;
  int            m_vl = 0;
  logic [DW-1:0] m_q[$];

  function automatic logic [VLEN-1:0] packed_word();
    logic [VLEN-1:0] r = '0;
    foreach (m_q[k]) r[k*DW +: DW] = m_q[k];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_vrd   = '0;
      m_vl    = 0;
      m_q.delete();
    end else if (m_phase == 0) begin
      if (cmd_valid_i) begin
        m_vrd = cmd_vrd_i;
        m_vl  = (int'(cmd_vl_i) > EL) ? EL : int'(cmd_vl_i);
        m_q.delete();
        m_phase = (m_vl == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (elem_valid_i) begin
        m_q.push_back(elem_data_i);
        if (m_q.size() == m_vl) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  int dut_hs = 0;
  int dut_wr = 0;
  int dut_done = 0;

  always @(negedge clk) begin
    chk("cmd_ready", VLEN'(cmd_ready_o), VLEN'(m_phase == 0));
    chk("elem_ready", VLEN'(elem_ready_o), VLEN'(m_phase == 1));
    chk("busy", VLEN'(busy_o), VLEN'(m_phase != 0));
    chk("done", VLEN'(done_o), VLEN'(m_phase == 2));
    chk("wen", VLEN'(vregw_en_o),
        VLEN'(m_phase == 2 && m_vrd != 0 && m_vl != 0));
    chk("addr", VLEN'(vrd_addr_o), VLEN'(m_vrd));
    chk("data", vrd_data_o, packed_word());
    dut_hs   += int'(elem_valid_i && elem_ready_o);
    dut_wr   += int'(vregw_en_o);
    dut_done += int'(done_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] vrd,
                          input int vl);
    cmd_valid_i = 1'b1;
    cmd_vrd_i   = vrd;
    cmd_vl_i    = VLW'(vl);
    cyc();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done_o && n < max) begin
      cyc();
      n++;
    end
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL done_timeout got=0 want=1 t=%0t", $time);
    end
  endtask

  int hs0, wr0, dn0;
  logic [VLEN-1:0] exp_w;

  initial begin
    #12;
    rst = 1'b0;
    cyc();

    // Async reset mid-cycle while gathering
    send_cmd(5'd9, 4);
    elem_valid_i = 1'b1;
    elem_data_i  = 32'hdead_beef;
    cyc();
    elem_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", VLEN'(busy_o), '0);
    chk("rst_cmd_ready", VLEN'(cmd_ready_o), VLEN'(1));
    chk("rst_elem_ready", VLEN'(elem_ready_o), '0);
    chk("rst_addr", VLEN'(vrd_addr_o), '0);
    chk("rst_data", vrd_data_o, '0);
    chk("rst_wen", VLEN'(vregw_en_o), '0);
    chk("rst_done", VLEN'(done_o), '0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", VLEN'(cmd_ready_o), VLEN'(1));

    // Full vector, back-to-back elements
    send_cmd(5'd5, 8);
    for (int i = 0; i < 8; i++) begin
      elem_valid_i = 1'b1;
      elem_data_i  = DW'((i + 1) * 32'h11);
      cyc();
    end
    elem_valid_i = 1'b0;
    exp_w = {32'h88, 32'h77, 32'h66, 32'h55,
             32'h44, 32'h33, 32'h22, 32'h11};
    chk("t2_wen", VLEN'(vregw_en_o), VLEN'(1));
    chk("t2_addr", VLEN'(vrd_addr_o), VLEN'(5));
    chk("t2_data", vrd_data_o, exp_w);
    chk("t2_done", VLEN'(done_o), VLEN'(1));
    cyc();
    chk("t2_next_ready", VLEN'(cmd_ready_o), VLEN'(1));

    // Short vector with producer gaps
    hs0 = dut_hs;
    wr0 = dut_wr;
    send_cmd(5'd3, 3);
    for (int i = 0; i < 3; i++) begin
      elem_valid_i = 1'b0;
      cyc();
      cyc();
      elem_valid_i = 1'b1;
      elem_data_i  = DW'(32'hA + i);
      cyc();
    end
    elem_valid_i = 1'b0;
    wait_done(10);
    exp_w = '0;
    exp_w[95:0] = {32'hC, 32'hB, 32'hA};
    chk("t3_data", vrd_data_o, exp_w);
    chk("t3_addr", VLEN'(vrd_addr_o), VLEN'(3));
    cyc();
    chk("t3_elem_ready", VLEN'(elem_ready_o), '0);
    chk("t3_hs", VLEN'(dut_hs - hs0), VLEN'(3));
    chk("t3_writes", VLEN'(dut_wr - wr0), VLEN'(1));

    // Destination v0: drain, no write
    hs0 = dut_hs;
    wr0 = dut_wr;
    dn0 = dut_done;
    send_cmd(5'd0, 2);
    for (int i = 0; i < 2; i++) begin
      elem_valid_i = 1'b1;
      elem_data_i  = DW'(32'h100 + i);
      cyc();
    end
    elem_valid_i = 1'b0;
    wait_done(5);
    cyc();
    chk("t4_hs", VLEN'(dut_hs - hs0), VLEN'(2));
    chk("t4_writes", VLEN'(dut_wr - wr0), '0);
    chk("t4_done", VLEN'(dut_done - dn0), VLEN'(1));

    // vl=0 completes immediately
    hs0 = dut_hs;
    elem_valid_i = 1'b1;
    send_cmd(5'd4, 0);
    chk("t5_done", VLEN'(done_o), VLEN'(1));
    chk("t5_wen", VLEN'(vregw_en_o), '0);
    cyc();
    chk("t5_hs0", VLEN'(dut_hs - hs0), '0);

    // vl=12 clamps to 8; extra offered elements ignored in IDLE
    hs0 = dut_hs;
    wr0 = dut_wr;
    send_cmd(5'd1, 12);
    for (int i = 0; i < 12; i++) begin
      elem_data_i = DW'($urandom);
      cyc();
    end
    elem_valid_i = 1'b0;
    cyc();
    chk("t5_hs_clamp", VLEN'(dut_hs - hs0), VLEN'(8));
    chk("t5_writes", VLEN'(dut_wr - wr0), VLEN'(1));

    // Reset aborts a partial vector
    wr0 = dut_wr;
    send_cmd(5'd7, 8);
    for (int i = 0; i < 4; i++) begin
      elem_valid_i = 1'b1;
      elem_data_i  = DW'(32'hF0 + i);
      cyc();
    end
    elem_valid_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_no_write", VLEN'(dut_wr - wr0), '0);
    send_cmd(5'd7, 1);
    elem_valid_i = 1'b1;
    elem_data_i  = 32'h5;
    cyc();
    elem_valid_i = 1'b0;
    wait_done(5);
    chk("t6_data", vrd_data_o, VLEN'(5));
    chk("t6_wen", VLEN'(vregw_en_o), VLEN'(1));
    chk("t6_addr", VLEN'(vrd_addr_o), VLEN'(7));
    cyc();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cmd_valid_i  = ($urandom_range(0, 3) == 0);
      cmd_vrd_i    = 5'($urandom_range(0, 31));
      cmd_vl_i     = VLW'($urandom_range(0, 15));
      elem_valid_i = ($urandom_range(0, 2) != 0);
      elem_data_i  = DW'($urandom);
      rst          = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst          = 1'b0;
    cmd_valid_i  = 1'b0;
    elem_valid_i = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vreg_wb_packer.md
Name: vreg_wb_packer

Overview:
- Element-serial writeback assembler and write-side master of the vector register file.
- Accepts a writeback command (destination vector register, element count vl), then collects vl elements of DATA_WIDTH bits, one per valid/ready handshake, from a lane or load path.
- Packs the elements into one VLEN-wide word and issues a single-cycle full-register write (enable, address, data) to the register file.

Parameters:
- DATA_WIDTH, 32, element width in bits
- ELEMENTS, 8, elements per vector register
- VLEN, DATA_WIDTH*ELEMENTS, register width in bits
- VLW, $clog2(ELEMENTS+1), width of the vl field

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-high
- cmd_valid_i  input  1  writeback command valid
- cmd_ready_o  output  1  command accepted when valid&&ready
- cmd_vrd_i  input  5  destination vector register
- cmd_vl_i  input  VLW  number of elements to collect
- elem_valid_i  input  1  element valid
- elem_ready_o  output  1  element consumed when valid&&ready
- elem_data_i  input  DATA_WIDTH  element payload
- vregw_en_o  output  1  register-file write enable
- vrd_addr_o  output  5  register-file write address
- vrd_data_o  output  VLEN  register-file write data
- busy_o  output  1  high in any state except IDLE
- done_o  output  1  one-cycle pulse when a command completes

Behaviour:
- State machine states: IDLE, COLLECT, WRITE.
- Internal registers: state, vrd_q[4:0], vl_q, idx (element counter), buf_q[VLEN-1:0].
- Reset while rst=1 (asynchronous, any state):
  - state=IDLE; vrd_q, vl_q, idx and buf_q cleared to 0.
  - Any partially collected vector is discarded with no write.
  - Output values: cmd_ready_o=1, elem_ready_o=0, vregw_en_o=0, vrd_addr_o=0, vrd_data_o=0, busy_o=0, done_o=0.
- IDLE:
  - cmd_ready_o=1, elem_ready_o=0; elements offered in IDLE are not consumed.
  - On command handshake: latch vrd_q=cmd_vrd_i and vl_q=min(cmd_vl_i, ELEMENTS); set buf_q=0 and idx=0.
  - If the clamped vl is 0: go to WRITE.
  - Otherwise: go to COLLECT.
- COLLECT:
  - cmd_ready_o=0, elem_ready_o=1.
  - On each element handshake: buf_q[idx*DATA_WIDTH +: DATA_WIDTH] <= elem_data_i; idx <= idx+1.
  - The handshake with idx==vl_q-1 moves to WRITE.
  - elem_valid_i low: the block holds state indefinitely.
- WRITE (exactly one cycle, then IDLE):
  - elem_ready_o=0, cmd_ready_o=0, done_o=1.
  - vregw_en_o=1 only if vrd_q!=0 and vl_q!=0.
- Element order: element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], so element 0 is in the LSBs.
- Tail elements k>=vl_q are written as zero; this is a full-register write.
- vrd_addr_o=vrd_q and vrd_data_o=buf_q at all times. Both are flop outputs; vregw_en_o and done_o decode directly from state flops.
- vrd=0: elements are still consumed to drain the producer; no write is issued; done_o still pulses.
- vl=0: no element is consumed, no write is issued, done_o pulses.
- Timing:
  - Command accepted at cycle T with no element stalls: elements are consumed T+1..T+vl, WRITE occurs at T+vl+1, and the next command can be accepted at T+vl+2.
  - Throughput is vl+2 cycles per command.

Test Plan:
1. Assert rst mid-clock with no clock edge -> all outputs at reset values immediately; after release cmd_ready_o=1, busy_o=0.
2. cmd vrd=5, vl=8 at cycle T; elements 0x11,0x22,...,0x88 back-to-back -> at T+9: vregw_en_o=1, vrd_addr_o=5, vrd_data_o=0x00000088_..._00000011 (elem0 in LSBs), done_o=1; cmd_ready_o=1 at T+10.
3. cmd vrd=3, vl=3; elements 0xA,0xB,0xC with 2-cycle valid gaps -> single write to v3 with elements 0..2 = A,B,C and elements 3..7 = 0; exactly 3 elem handshakes; elem_ready_o low after the write.
4. cmd vrd=0, vl=2; two elements -> both consumed, vregw_en_o never high, done_o pulses once.
5. cmd vl=0 -> WRITE the next cycle with no element consumed, vregw_en_o=0, done_o=1. cmd vl=12 with vrd=1 -> exactly 8 elements consumed, one write to v1.
6. cmd vrd=7, vl=8; assert rst after 4 elements -> no write; after release, cmd vrd=7, vl=1 with element 0x5 -> vrd_data_o=0x...0005 with all other bits 0.
